// File: rtl/mac_pkg.sv
// Shared types and the requantise helper for the mac_bank writeback paths.
package mac_pkg;

    localparam int POX_DEF = 3;
    localparam int IDXW    = $clog2(POX_DEF);

    typedef enum logic {IDLE, SEND} drain_st_e;

    // Arithmetic shift, optional ReLU, then saturate to a signed odw-bit range.
    // Works at 64 bits so any result width up to 64 fits after sign extension.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                     input int unsigned shift,
                                                     input bit relu,
                                                     input int unsigned odw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s = v >>> shift;
        if (relu && s < 0) s = '0;
        hi = (64'sd1 <<< (odw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        return s;
    endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Bank-result capture side and requantised output stream of mac_result_drain.
interface mac_result_drain_if #(
    parameter int DW   = 32,
    parameter int POX  = 3,
    parameter int ODW  = 16,
    parameter int IDXW = 2
);
    logic [DW-1:0]   result [POX];
    logic            cnt_c  [POX];
    logic [ODW-1:0]  out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            bank_stall;
    logic            err_align;
    logic            err_ovf;

    // A beat transfers on a rising edge where out_valid && out_ready; once
    // raised, out_valid and its data/idx/last hold until that transfer.
    modport master (
        output result, cnt_c, out_ready,
        input  out_data, out_idx, out_last, out_valid, bank_stall, err_align, err_ovf
    );

    modport slave (
        input  result, cnt_c, out_ready,
        output out_data, out_idx, out_last, out_valid, bank_stall, err_align, err_ovf
    );
endinterface

// File: rtl/mac_frame_fifo.sv
// Two-entry FIFO of whole result frames; push and pop may share a cycle.
module mac_frame_fifo #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mac_result_drain.sv
// Captures mac_bank lane results, requantises them and streams one lane per beat.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int DW    = 32,
    parameter int POX   = 3,
    parameter int ODW   = 16,
    parameter int SHIFT = 4,
    parameter int RELU  = 0
) (
    input  logic      clk,
    input  logic      rst,
    mac_result_drain_if.slave bus,
    output drain_st_e dbg_state
);

    localparam int IW = (POX > 1) ? $clog2(POX) : 1;
    localparam int FW = POX * DW;

    logic [FW-1:0]  wr_frame;
    logic [FW-1:0]  rd_frame;
    logic [DW-1:0]  lane [POX];
    logic [DW-1:0]  lane_sel;
    logic [ODW-1:0] out_word;
    logic [1:0]     count;
    logic [1:0]     count_nx;
    logic           any_c;
    logic           cap;
    logic           push;
    logic           pop;

    drain_st_e      st;
    logic [IW-1:0]  idx_q;
    logic           valid_q;
    logic           last_q;
    logic           stall_q;
    logic           err_align_q;
    logic           err_ovf_q;

    always_comb begin
        any_c    = 1'b0;
        cap      = 1'b1;
        wr_frame = '0;
        for (int i = 0; i < POX; i++) begin
            any_c = any_c | bus.cnt_c[i];
            cap   = cap & bus.cnt_c[i];
            wr_frame[i*DW +: DW] = bus.result[i];
        end
    end

    always_comb begin
        for (int i = 0; i < POX; i++) lane[i] = rd_frame[i*DW +: DW];
    end

    // A final-beat pop frees the slot a same-cycle capture needs when full.
    assign pop      = (st == SEND) && bus.out_ready && (idx_q == IW'(POX - 1));
    assign push     = cap && ((count != 2'd2) || pop);
    assign count_nx = count + {1'b0, push} - {1'b0, pop};

    mac_frame_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_frame),
        .rd_data (rd_frame),
        .count   (count)
    );

    assign lane_sel = lane[idx_q];
    assign out_word = ODW'(sat_shift(64'($signed(lane_sel)), SHIFT, RELU != 0, ODW));

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            stall_q     <= 1'b0;
            err_align_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            stall_q <= (count_nx == 2'd2);
            if (any_c && !cap) err_align_q <= 1'b1;
            if (cap && !push)  err_ovf_q   <= 1'b1;
            case (st)
                IDLE: begin
                    if (count != 2'd0) begin
                        st      <= SEND;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        last_q  <= (POX == 1);
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (idx_q == IW'(POX - 1)) begin
                            idx_q  <= '0;
                            last_q <= (POX == 1) && (count_nx != 2'd0);
                            if (count_nx == 2'd0) begin
                                st      <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            last_q <= ((idx_q + 1'b1) == IW'(POX - 1));
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.out_data   = valid_q ? out_word : '0;
    assign bus.out_idx    = idx_q;
    assign bus.out_last   = last_q;
    assign bus.out_valid  = valid_q;
    assign bus.bank_stall = stall_q;
    assign bus.err_align  = err_align_q;
    assign bus.err_ovf    = err_ovf_q;
    assign dbg_state      = st;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: RELU=0 and RELU=1 instances on identical stimulus.
module tb_mac_result_drain;
  import mac_pkg::*;

  localparam int POX = 3;

  logic clk;
  logic rst;
  drain_st_e dbg0;
  drain_st_e dbg1;

  mac_result_drain_if #(.DW(32), .POX(3), .ODW(16), .IDXW(2)) bus0 ();
  mac_result_drain_if #(.DW(32), .POX(3), .ODW(16), .IDXW(2)) bus1 ();

  mac_result_drain #(.DW(32), .POX(3), .ODW(16), .SHIFT(4), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
  );
  mac_result_drain #(.DW(32), .POX(3), .ODW(16), .SHIFT(4), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // entry: {last, idx[1:0], relu1_word[15:0], relu0_word[15:0]}
  logic [34:0] exp_q[$];

  // reference model state (committed at each rising edge)
  int m_nfr = 0;
  int m_beat = 0;
  bit m_vld = 0;
  bit m_align = 0;
  bit m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_q(input logic [31:0] r, input bit relu);
    longint v;
    longint s;
    logic [63:0] u;
    v = longint'($signed(r));
    s = v >>> 4;
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    u = s;
    return u[15:0];
  endfunction

  task automatic set_inputs(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [2:0] cc, input logic rdy);
    bus0.result[0] = r0; bus0.result[1] = r1; bus0.result[2] = r2;
    bus1.result[0] = r0; bus1.result[1] = r1; bus1.result[2] = r2;
    for (int i = 0; i < POX; i++) begin
      bus0.cnt_c[i] = cc[i];
      bus1.cnt_c[i] = cc[i];
    end
    bus0.out_ready = rdy;
    bus1.out_ready = rdy;
  endtask

  // driver: one clock of stimulus, with the reference model advanced alongside
  task automatic drive(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [2:0] cc, input logic rdy);
    bit all_c, any_c, popm, acc;
    int n_nfr, n_beat;
    bit n_vld, n_align, n_ovf;
    logic [31:0] rv [3];
    @(negedge clk);
    set_inputs(r0, r1, r2, cc, rdy);
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    all_c = (cc == 3'b111);
    any_c = (cc != 3'b000);
    popm = m_vld && rdy && (m_beat == POX - 1);
    acc = all_c && (m_nfr < 2 || popm);
    n_align = m_align | (any_c && !all_c);
    n_ovf = m_ovf | (all_c && !acc);
    n_nfr = m_nfr - int'(popm) + int'(acc);
    if (acc) begin
      for (int i = 0; i < POX; i++) begin
        logic [1:0] ix;
        ix = 2'(i);
        exp_q.push_back({(i == POX - 1), ix, ref_q(rv[i], 1'b1), ref_q(rv[i], 1'b0)});
      end
    end
    n_vld = m_vld;
    n_beat = m_beat;
    if (!m_vld) begin
      if (m_nfr > 0) begin n_vld = 1; n_beat = 0; end
    end else if (rdy) begin
      if (m_beat == POX - 1) begin n_beat = 0; n_vld = (n_nfr > 0); end
      else n_beat = m_beat + 1;
    end
    @(posedge clk);
    m_nfr = n_nfr; m_beat = n_beat; m_vld = n_vld; m_align = n_align; m_ovf = n_ovf;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) drive(32'd0, 32'd0, 32'd0, 3'b000, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_inputs(32'd0, 32'd0, 32'd0, 3'b000, 1'b0);
    @(posedge clk);
    m_nfr = 0; m_beat = 0; m_vld = 0; m_align = 0; m_ovf = 0;
    exp_q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, "_data0"}, 32'(bus0.out_data), 32'd0);
    chk({tag, "_data1"}, 32'(bus1.out_data), 32'd0);
    chk({tag, "_idx"}, 32'(bus0.out_idx), 32'd0);
    chk({tag, "_last"}, 32'(bus0.out_last), 32'd0);
    chk({tag, "_stall"}, 32'(bus0.bank_stall), 32'd0);
    chk({tag, "_ealign"}, 32'(bus0.err_align), 32'd0);
    chk({tag, "_eovf"}, 32'(bus0.err_ovf), 32'd0);
  endtask

  // scoreboard monitor: status every cycle, data popped on each accepted beat
  always begin
    logic [34:0] e;
    @(negedge clk);
    #1;
    if (!rst) begin
      chk("out_valid0", 32'(bus0.out_valid), 32'(m_vld));
      chk("out_valid1", 32'(bus1.out_valid), 32'(m_vld));
      chk("bank_stall0", 32'(bus0.bank_stall), 32'(m_nfr == 2));
      chk("bank_stall1", 32'(bus1.bank_stall), 32'(m_nfr == 2));
      chk("err_align", 32'(bus0.err_align), 32'(m_align));
      chk("err_ovf", 32'(bus0.err_ovf), 32'(m_ovf));
      chk("err_ovf1", 32'(bus1.err_ovf), 32'(m_ovf));
      if (bus0.out_valid && bus0.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got beat idx %0d expected none at %0t", bus0.out_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data0", 32'(bus0.out_data), 32'(e[15:0]));
          chk("out_data1", 32'(bus1.out_data), 32'(e[31:16]));
          chk("out_idx", 32'(bus0.out_idx), 32'(e[33:32]));
          chk("out_last", 32'(bus0.out_last), 32'(e[34]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_inputs(32'd0, 32'd0, 32'd0, 3'b000, 1'b0);
    do_reset();
    check_reset_outputs("reset");

    // basic frame, consecutive beats
    drive(32'h100, 32'h200, 32'h300, 3'b111, 1'b1);
    idle(1'b1, 6);

    // saturation in both directions, negative under ReLU
    drive(32'h0010_0000, -32'sh0010_0000, -32'sh40, 3'b111, 1'b1);
    idle(1'b1, 6);

    // back-pressure: fill, overflow, then drain two frames
    do_reset();
    drive(32'h1111, 32'h2222, 32'h3333, 3'b111, 1'b0);
    idle(1'b0, 2);
    drive(32'h4444, 32'h5555, 32'h6666, 3'b111, 1'b0);
    idle(1'b0, 1);
    drive(32'h7777, 32'h8888, 32'h9999, 3'b111, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 10);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);

    // lane disagreement
    do_reset();
    drive(32'h10, 32'h20, 32'h30, 3'b101, 1'b1);
    idle(1'b1, 3);

    // final pop coincides with capture while full
    do_reset();
    drive(32'hA0, 32'hB0, 32'hC0, 3'b111, 1'b0);
    drive(-32'sh50, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 1'b0);
    for (int k = 0; k < 10 && !(m_vld && m_beat == POX - 1); k++) idle(1'b1, 1);
    drive(32'hD0, 32'hE0, 32'hF0, 3'b111, 1'b1);
    idle(1'b1, 10);

    // reset mid-frame after the idx1 beat
    do_reset();
    drive(32'h123, 32'h456, 32'h789, 3'b111, 1'b1);
    for (int k = 0; k < 10 && !(m_vld && m_beat == 2); k++) idle(1'b1, 1);
    do_reset();
    check_reset_outputs("midrst");
    drive(32'h321, 32'h654, 32'h987, 3'b111, 1'b1);
    idle(1'b1, 6);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [31:0] r [3];
      logic [2:0] cc;
      int u;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 1) r[i] = $urandom();
        else r[i] = 32'(int'($urandom_range(0, 1048575)) - 524288);
      end
      u = int'($urandom_range(0, 19));
      if (u < 6) cc = 3'b111;
      else if (u == 6) cc = 3'($urandom_range(1, 6));
      else cc = 3'b000;
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive(r[0], r[1], r[2], cc, $urandom_range(0, 3) != 0);
    end
    idle(1'b1, 12);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
